// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation sequencer: FSM state encoding and fault codes.
package irrigation_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSettle   = 3'd1,
        StIrrigate = 3'd2,
        StPause    = 3'd3,
        StFault    = 3'd4
    } state_e;

    localparam logic [1:0] FaultNone        = 2'b00;
    localparam logic [1:0] FaultConflict    = 2'b01;
    localparam logic [1:0] FaultFillTimeout = 2'b10;

    localparam int unsigned DefaultTimeWidth = 9;

endpackage

// File: rtl/irrigation_sequencer_tick_countdown.sv
// Loadable down-counter that steps once per tick enable, saturates at zero and flags zero.
module tick_countdown #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_tick,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation controller: pump/dripper sequencing with a dead-time settle phase, low-water pause,
// refill valve with hysteresis and fill timeout, and latched faults.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int unsigned TIME_WIDTH     = DefaultTimeWidth,
    parameter int unsigned SPRINKLER_TIME = 300,
    parameter int unsigned DRIPPER_TIME   = 420,
    parameter int unsigned SETTLE_TICKS   = 2,
    parameter int unsigned FILL_TIMEOUT   = 120
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_tick,
    input  logic                  i_low_water_level,
    input  logic                  i_mid_water_level,
    input  logic                  i_high_water_level,
    input  logic                  i_earth_humidity,
    input  logic                  i_splinker_request,
    input  logic                  i_auto_enable,
    input  logic                  i_stop_pulse,
    input  logic                  i_fault_clear,
    output logic                  o_water_supply_valvule,
    output logic                  o_splinker_bomb,
    output logic                  o_dripper_valvule,
    output logic                  o_alarm,
    output logic [TIME_WIDTH-1:0] o_remaining_seconds,
    output logic [2:0]            o_state_code,
    output logic [1:0]            o_fault_code
);

    localparam logic [TIME_WIDTH-1:0] SprinklerTicks = TIME_WIDTH'(SPRINKLER_TIME);
    localparam logic [TIME_WIDTH-1:0] DripperTicks   = TIME_WIDTH'(DRIPPER_TIME);
    localparam logic [TIME_WIDTH-1:0] SettleTicks    = TIME_WIDTH'(SETTLE_TICKS);
    localparam logic [TIME_WIDTH-1:0] FillTicks      = TIME_WIDTH'(FILL_TIMEOUT);
    localparam logic [TIME_WIDTH-1:0] OneTick        = TIME_WIDTH'(1);

    state_e                r_state, w_state_next;
    logic                  r_mode, w_mode_next;
    logic [1:0]            r_fault_code, w_fault_next;
    logic                  r_valve, w_valve_next;
    logic                  r_pump, w_pump_next;
    logic                  r_drip, w_drip_next;
    logic                  r_alarm, w_alarm_next;

    logic                  w_irr_load, w_irr_dec, w_irr_zero;
    logic [TIME_WIDTH-1:0] w_irr_load_val, w_irr_count;
    logic                  w_settle_load, w_settle_dec, w_settle_zero;
    logic [TIME_WIDTH-1:0] w_settle_count;
    logic                  w_fill_load, w_fill_dec, w_fill_zero;
    logic [TIME_WIDTH-1:0] w_fill_count;

    logic w_conflict, w_fill_expired, w_settle_done, w_irr_expired, w_mode_change;

    assign w_conflict = (i_mid_water_level & ~i_low_water_level)
                      | (i_high_water_level & ~i_mid_water_level);
    assign w_fill_expired = r_valve & (w_fill_zero | (i_tick & (w_fill_count == OneTick)));
    assign w_settle_done  = w_settle_zero | (i_tick & (w_settle_count == OneTick));
    assign w_irr_expired  = i_tick & (w_irr_zero | (w_irr_count == OneTick));
    assign w_mode_change  = (i_splinker_request != r_mode);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_mode       <= 1'b0;
            r_fault_code <= FaultNone;
            r_valve      <= 1'b0;
            r_pump       <= 1'b0;
            r_drip       <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mode       <= w_mode_next;
            r_fault_code <= w_fault_next;
            r_valve      <= w_valve_next;
            r_pump       <= w_pump_next;
            r_drip       <= w_drip_next;
            r_alarm      <= w_alarm_next;
        end
    end

    // Faults pre-empt every state; only the first cause is recorded.
    always_comb begin
        w_state_next = r_state;
        w_fault_next = r_fault_code;
        if (w_conflict) begin
            w_state_next = StFault;
            if (r_state != StFault) w_fault_next = FaultConflict;
        end else if (w_fill_expired) begin
            w_state_next = StFault;
            if (r_state != StFault) w_fault_next = FaultFillTimeout;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_auto_enable && !i_earth_humidity && i_low_water_level) begin
                        w_state_next = StSettle;
                    end
                end
                StSettle: begin
                    if (i_stop_pulse || i_earth_humidity) w_state_next = StIdle;
                    else if (!i_low_water_level)          w_state_next = StPause;
                    else if (w_settle_done)               w_state_next = StIrrigate;
                end
                StIrrigate: begin
                    if (i_stop_pulse || i_earth_humidity) w_state_next = StIdle;
                    else if (!i_low_water_level)          w_state_next = StPause;
                    else if (w_mode_change)               w_state_next = StSettle;
                    else if (w_irr_expired)               w_state_next = StIdle;
                end
                StPause: begin
                    if (i_stop_pulse || i_earth_humidity) w_state_next = StIdle;
                    else if (i_mid_water_level)           w_state_next = StSettle;
                end
                StFault: begin
                    if (i_fault_clear) begin
                        w_state_next = StIdle;
                        w_fault_next = FaultNone;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_mode_next    = r_mode;
        w_irr_load     = 1'b0;
        w_irr_load_val = '0;
        // A fresh start or a mode change relatches the mode; resuming from PAUSE keeps both.
        if ((r_state == StIdle || r_state == StIrrigate) && w_state_next == StSettle) begin
            w_mode_next    = i_splinker_request;
            w_irr_load     = 1'b1;
            w_irr_load_val = i_splinker_request ? SprinklerTicks : DripperTicks;
        end else if (w_state_next == StIdle || w_state_next == StFault) begin
            w_irr_load = 1'b1;
        end
        w_irr_dec     = i_tick & (r_state == StIrrigate) & (w_state_next == StIrrigate);
        w_settle_load = (w_state_next == StSettle) & (r_state != StSettle);
        w_settle_dec  = i_tick & (r_state == StSettle);

        w_valve_next = r_valve;
        if (w_state_next == StFault)  w_valve_next = 1'b0;
        else if (i_high_water_level)  w_valve_next = 1'b0;
        else if (!i_mid_water_level)  w_valve_next = 1'b1;
        w_fill_load = w_valve_next & ~r_valve;
        w_fill_dec  = i_tick & r_valve;

        w_pump_next  = (w_state_next == StIrrigate) &  w_mode_next;
        w_drip_next  = (w_state_next == StIrrigate) & ~w_mode_next;
        w_alarm_next = (w_state_next == StFault);
    end

    tick_countdown #(.WIDTH(TIME_WIDTH)) u_irr_timer (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_load       (w_irr_load),
        .i_load_value (w_irr_load_val),
        .i_tick       (w_irr_dec),
        .o_count      (w_irr_count),
        .o_zero       (w_irr_zero)
    );

    tick_countdown #(.WIDTH(TIME_WIDTH)) u_settle_timer (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_load       (w_settle_load),
        .i_load_value (SettleTicks),
        .i_tick       (w_settle_dec),
        .o_count      (w_settle_count),
        .o_zero       (w_settle_zero)
    );

    tick_countdown #(.WIDTH(TIME_WIDTH)) u_fill_timer (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_load       (w_fill_load),
        .i_load_value (FillTicks),
        .i_tick       (w_fill_dec),
        .o_count      (w_fill_count),
        .o_zero       (w_fill_zero)
    );

    assign o_water_supply_valvule = r_valve;
    assign o_splinker_bomb        = r_pump;
    assign o_dripper_valvule      = r_drip;
    assign o_alarm                = r_alarm;
    assign o_remaining_seconds    = w_irr_count;
    assign o_state_code           = r_state;
    assign o_fault_code           = r_fault_code;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed bench for irrigation_sequencer with hand-computed expectations.
module tb_irrigation_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       low = 1'b1, mid = 1'b1, high = 1'b1;
    logic       hum = 1'b0, req = 1'b0, auto_en = 1'b0, stop = 1'b0, fclr = 1'b0;
    logic       valve, pump, drip, alarm;
    logic [8:0] rem;
    logic [2:0] state;
    logic [1:0] fcode;

    int n_cmp = 0;
    int n_err = 0;
    int n_overlap = 0;

    irrigation_sequencer dut (
        .i_clock                (clock),
        .i_reset_n              (reset_n),
        .i_tick                 (tick),
        .i_low_water_level      (low),
        .i_mid_water_level      (mid),
        .i_high_water_level     (high),
        .i_earth_humidity       (hum),
        .i_splinker_request     (req),
        .i_auto_enable          (auto_en),
        .i_stop_pulse           (stop),
        .i_fault_clear          (fclr),
        .o_water_supply_valvule (valve),
        .o_splinker_bomb        (pump),
        .o_dripper_valvule      (drip),
        .o_alarm                (alarm),
        .o_remaining_seconds    (rem),
        .o_state_code           (state),
        .o_fault_code           (fcode)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (reset_n && pump && drip) n_overlap++;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic start_cycle(input logic mode);
        req = mode;
        auto_en = 1'b1;
        step();
        auto_en = 1'b0;
    endtask

    initial begin
        #3;
        check_val("rst_state", state, 0);
        check_val("rst_valves", {valve, pump, drip, alarm}, 0);
        check_val("rst_rem", rem, 0);
        check_val("rst_fcode", fcode, 0);
        reset_n = 1'b1;
        step();
        check_val("idle_state", state, 0);

        // Normal dripper cycle
        start_cycle(1'b0);
        check_val("dr_settle", state, 1);
        check_val("dr_load", rem, 420);
        check_val("dr_off_in_settle", drip, 0);
        tick_n(1);
        check_val("dr_settle_1tick", state, 1);
        tick_n(1);
        check_val("dr_irrigate", state, 2);
        check_val("dr_on", {pump, drip}, 2'b01);
        check_val("dr_rem_hold", rem, 420);
        tick_n(1);
        check_val("dr_rem_dec", rem, 419);
        tick_n(418);
        check_val("dr_rem_last", rem, 1);
        check_val("dr_still_irr", state, 2);
        tick_n(1);
        check_val("dr_done_state", state, 0);
        check_val("dr_done_outs", {valve, pump, drip, alarm}, 0);
        check_val("dr_done_rem", rem, 0);

        // Mode change sprinkler -> dripper
        start_cycle(1'b1);
        check_val("mc_load", rem, 300);
        tick_n(2);
        check_val("mc_pump_on", {pump, drip}, 2'b10);
        tick_n(200);
        check_val("mc_rem100", rem, 100);
        req = 1'b0;
        step();
        check_val("mc_settle", state, 1);
        check_val("mc_all_off", {pump, drip}, 0);
        check_val("mc_reload", rem, 420);
        tick_n(1);
        check_val("mc_still_settle", state, 1);
        tick_n(1);
        check_val("mc_drip_on", {pump, drip}, 2'b01);
        check_val("mc_rem", rem, 420);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("mc_stop", state, 0);

        // Low-water pause, with a tick in the same cycle as the exit
        start_cycle(1'b0);
        tick_n(2);
        tick_n(170);
        check_val("lw_rem250", rem, 250);
        {low, mid, high} = 3'b000;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check_val("lw_pause", state, 3);
        check_val("lw_frozen", rem, 250);
        check_val("lw_outs", {valve, pump, drip}, 3'b100);
        tick_n(5);
        check_val("lw_still_frozen", rem, 250);
        {low, mid} = 2'b11;
        step();
        check_val("lw_resettle", state, 1);
        check_val("lw_keep_rem", rem, 250);
        tick_n(2);
        check_val("lw_resume", state, 2);
        check_val("lw_resume_drip", drip, 1);
        tick_n(1);
        check_val("lw_rem249", rem, 249);
        high = 1'b1;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("lw_end", {state, valve}, 0);

        // Fill timeout
        {low, mid, high} = 3'b100;
        step();
        check_val("ft_open", valve, 1);
        tick_n(119);
        check_val("ft_not_yet", {state, alarm}, 0);
        tick_n(1);
        check_val("ft_fault", state, 4);
        check_val("ft_code", fcode, 2);
        check_val("ft_alarm_valve", {alarm, valve}, 2'b10);
        fclr = 1'b1;
        step();
        fclr = 1'b0;
        check_val("ft_clear", state, 0);
        check_val("ft_code_clr", {fcode, alarm}, 0);
        {low, mid, high} = 3'b111;
        step();
        check_val("ft_close", valve, 0);

        // Sensor conflict
        start_cycle(1'b1);
        tick_n(2);
        check_val("cf_irr", pump, 1);
        mid = 1'b0;
        step();
        check_val("cf_fault", state, 4);
        check_val("cf_code", fcode, 1);
        check_val("cf_outs", {valve, pump, drip, alarm}, 4'b0001);
        fclr = 1'b1;
        step();
        fclr = 1'b0;
        check_val("cf_clr_ignored", {state, fcode}, {3'd4, 2'd1});
        mid = 1'b1;
        fclr = 1'b1;
        step();
        fclr = 1'b0;
        check_val("cf_cleared", {state, fcode}, 0);

        // Stop, tick and mode change together
        start_cycle(1'b1);
        tick_n(2);
        tick_n(10);
        check_val("sim_rem", rem, 290);
        stop = 1'b1;
        tick = 1'b1;
        req  = 1'b0;
        step();
        {stop, tick} = 2'b00;
        check_val("sim_idle", state, 0);
        check_val("sim_rem0", rem, 0);
        check_val("sim_off", {pump, drip}, 0);

        // Asynchronous reset mid-irrigation
        start_cycle(1'b0);
        tick_n(5);
        check_val("ar_drip", drip, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("ar_outs", {valve, pump, drip, alarm}, 0);
        check_val("ar_state_rem", {state, rem}, 0);
        #2;
        reset_n = 1'b1;
        step();
        check_val("ar_after", state, 0);

        check_val("no_overlap", n_overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
